// File: rtl/line_buffer_3row_if.sv
// rtl/line_buffer_3row_if.sv - pixel stream in, vertical triple out for the 3-row line buffer
interface line_buffer_3row_if #(
    parameter int width = 8
);
    logic             pix_valid;
    logic [width-1:0] pix_in;
    logic [width-1:0] out_1;
    logic [width-1:0] out_2;
    logic [width-1:0] out_3;
    logic             read_ready;
    logic             frame_done;

    modport master (
        output pix_valid,
        output pix_in,
        input  out_1,
        input  out_2,
        input  out_3,
        input  read_ready,
        input  frame_done
    );

    modport slave (
        input  pix_valid,
        input  pix_in,
        output out_1,
        output out_2,
        output out_3,
        output read_ready,
        output frame_done
    );
endinterface

// File: rtl/line_buffer_3row.sv
// rtl/line_buffer_3row.sv - two-row-memory line buffer emitting vertical pixel triples
module line_buffer_3row #(
    parameter int width = 8,
    parameter int img_w = 16,
    parameter int img_h = 16
) (
    input  logic               clk,
    input  logic               rst,
    line_buffer_3row_if.slave  bus
);
    localparam int CW = $clog2(img_w);
    localparam int RW = $clog2(img_h);

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [width-1:0]  out_1_q, out_1_d;
    logic [width-1:0]  out_2_q, out_2_d;
    logic [width-1:0]  out_3_q, out_3_d;
    logic              read_ready_q, read_ready_d;
    logic              frame_done_q, frame_done_d;

    // Contents are never reset; two full rows are rewritten before any triple is flagged.
    logic [width-1:0]  row_a_q [img_w];
    logic [width-1:0]  row_b_q [img_w];

    logic accept;
    logic col_last;
    logic row_last;

    assign accept   = bus.pix_valid;
    assign col_last = (col_q == CW'(img_w - 1));
    assign row_last = (row_q == RW'(img_h - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (accept && col_last && (row_q == RW'(1))) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept && col_last && row_last) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        read_ready_d = accept && (state_q == STREAM);
        frame_done_d = read_ready_d && col_last && row_last;
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        out_1_d = out_1_q;
        out_2_d = out_2_q;
        out_3_d = out_3_q;
        if (accept) begin
            out_1_d = bus.pix_in;
            out_2_d = row_a_q[col_q];
            out_3_d = row_b_q[col_q];
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_1_q      <= '0;
            out_2_q      <= '0;
            out_3_q      <= '0;
            read_ready_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_1_q      <= out_1_d;
            out_2_q      <= out_2_d;
            out_3_q      <= out_3_d;
            read_ready_q <= read_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Old row_a moves down to row_b in the same edge that its value is read out.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            row_b_q[col_q] <= row_a_q[col_q];
            row_a_q[col_q] <= bus.pix_in;
        end
    end

    assign bus.out_1      = out_1_q;
    assign bus.out_2      = out_2_q;
    assign bus.out_3      = out_3_q;
    assign bus.read_ready = read_ready_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_line_buffer_3row.sv
// tb/tb_line_buffer_3row.sv - directed and randomized checks of line_buffer_3row against a frame model
module tb_line_buffer_3row;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    line_buffer_3row_if #(.width(PW)) bus ();

    line_buffer_3row #(.width(PW), .img_w(W), .img_h(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Frame model: pixels stored at their raster position in the current frame.
    logic [PW-1:0] img [H][W];
    int            m_r = 0;
    int            m_c = 0;
    logic          e_rr = 1'b0;
    logic          e_fd = 1'b0;
    logic [PW-1:0] e_o1 = '0;
    logic [PW-1:0] e_o2 = '0;
    logic [PW-1:0] e_o3 = '0;
    bit            e_k23 = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_r = 0; m_c = 0;
            e_rr = 1'b0; e_fd = 1'b0;
            e_o1 = '0; e_o2 = '0; e_o3 = '0;
            e_k23 = 1'b1;
        end else if (bus.pix_valid) begin
            img[m_r][m_c] = bus.pix_in;
            e_o1 = bus.pix_in;
            if (m_r >= 2) begin
                e_rr  = 1'b1;
                e_o2  = img[m_r-1][m_c];
                e_o3  = img[m_r-2][m_c];
                e_k23 = 1'b1;
                e_fd  = (m_r == H-1) && (m_c == W-1);
            end else begin
                e_rr  = 1'b0;
                e_fd  = 1'b0;
                e_k23 = 1'b0;
            end
            m_c++;
            if (m_c == W) begin
                m_c = 0;
                m_r = (m_r == H-1) ? 0 : m_r + 1;
            end
        end else begin
            e_rr = 1'b0;
            e_fd = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("model_read_ready", 32'(bus.read_ready), 32'(e_rr));
                chk("model_frame_done", 32'(bus.frame_done), 32'(e_fd));
                chk("model_out_1", 32'(bus.out_1), 32'(e_o1));
                if (e_k23) begin
                    chk("model_out_2", 32'(bus.out_2), 32'(e_o2));
                    chk("model_out_3", 32'(bus.out_3), 32'(e_o3));
                end
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic [PW-1:0] p);
        rst           = r;
        bus.pix_valid = v;
        bus.pix_in    = p;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.pix_valid = 1'b0;
    endtask

    task automatic lit(input string name, input logic rr, input logic fd,
                       input logic [PW-1:0] o1, input logic [PW-1:0] o2, input logic [PW-1:0] o3);
        chk({name, "_rr"}, 32'(bus.read_ready), 32'(rr));
        chk({name, "_fd"}, 32'(bus.frame_done), 32'(fd));
        chk({name, "_o1"}, 32'(bus.out_1), 32'(o1));
        chk({name, "_o2"}, 32'(bus.out_2), 32'(o2));
        chk({name, "_o3"}, 32'(bus.out_3), 32'(o3));
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        lit("reset", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'(i));
            chk("fill_rr", 32'(bus.read_ready), 32'd0);
            chk("fill_fd", 32'(bus.frame_done), 32'd0);
        end
        step(1'b0, 1'b1, 8'd8);
        lit("pix8", 1'b1, 1'b0, 8'd8, 8'd4, 8'd0);
        step(1'b0, 1'b1, 8'd9);
        lit("pix9", 1'b1, 1'b0, 8'd9, 8'd5, 8'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'hEE);
            lit("idle_hold", 1'b0, 1'b0, 8'd9, 8'd5, 8'd1);
        end
        step(1'b0, 1'b1, 8'd10);
        lit("pix10", 1'b1, 1'b0, 8'd10, 8'd6, 8'd2);
        step(1'b0, 1'b1, 8'd11);
        lit("pix11", 1'b1, 1'b0, 8'd11, 8'd7, 8'd3);
        for (int i = 12; i < 15; i++) step(1'b0, 1'b1, 8'(i));
        step(1'b0, 1'b1, 8'd15);
        lit("pix15", 1'b1, 1'b1, 8'd15, 8'd11, 8'd7);
        step(1'b0, 1'b1, 8'd100);
        chk("after_frame_rr", 32'(bus.read_ready), 32'd0);
        chk("after_frame_fd", 32'(bus.frame_done), 32'd0);
        chk("after_frame_o1", 32'(bus.out_1), 32'd100);

        for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, 8'(i));
        step(1'b1, 1'b1, 8'd77);
        lit("mid_reset", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'(200 + i));
            chk("refill_rr", 32'(bus.read_ready), 32'd0);
            chk("refill_fd", 32'(bus.frame_done), 32'd0);
        end
        step(1'b0, 1'b1, 8'd208);
        lit("refill9", 1'b1, 1'b0, 8'd208, 8'd204, 8'd200);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 400) == 0, ($urandom % 4) != 0, 8'($urandom));
        end
        step(1'b0, 1'b0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
